// File: rtl/dct_block_scheduler.sv
// dct_block_scheduler: double-buffered sequencer for the 8x8 DCT engine, with block/frame counting
module dct_block_scheduler #(
  parameter int BLOCKS_PER_FRAME = 1200,
  parameter int CNT_W = 11
) (
  input  logic             clock,
  input  logic             nreset,
  output logic             in_ready,
  output logic             wr_bank,
  input  logic             in_commit,
  output logic [6:0]       in_raddr,
  output logic             dct_nreset,
  input  logic [5:0]       dct_fetch_addr,
  input  logic [5:0]       dct_result_addr,
  input  logic             dct_result_wren,
  input  logic             dct_finished,
  output logic [6:0]       res_waddr,
  output logic             res_wren,
  output logic             out_valid,
  output logic             out_bank,
  input  logic             out_ack,
  output logic [CNT_W-1:0] block_index,
  output logic             frame_done,
  output logic             busy,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, START, RUN, RETIRE} state_t;
  state_t state, state_nx;
  logic [1:0] in_full, res_full, in_full_nx, res_full_nx;
  logic rd_bank, res_wr_bank, first_run, commit_ok, ack_ok, retire, last;
  assign in_ready   = !in_full[wr_bank];
  assign out_valid  = res_full[out_bank];
  assign in_raddr   = {rd_bank, dct_fetch_addr};
  assign res_waddr  = {res_wr_bank, dct_result_addr};
  assign res_wren   = dct_result_wren && state == RUN;
  assign busy       = state != IDLE;
  assign dct_nreset = state == RUN;
  assign commit_ok  = in_commit && in_ready;
  assign ack_ok     = out_ack && out_valid;
  assign retire     = state == RETIRE;
  assign last       = block_index == CNT_W'(BLOCKS_PER_FRAME - 1);
  // first_run masks a dct_finished left over from the previous block
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (in_full[rd_bank] && !res_full[res_wr_bank]) ? START : IDLE;
      START:   state_nx = RUN;
      RUN:     state_nx = (dct_finished && !first_run) ? RETIRE : RUN;
      default: state_nx = IDLE;
    endcase
    in_full_nx  = in_full;
    res_full_nx = res_full;
    if (retire) in_full_nx[rd_bank] = 1'b0;
    if (commit_ok) in_full_nx[wr_bank] = 1'b1;
    if (ack_ok) res_full_nx[out_bank] = 1'b0;
    if (retire) res_full_nx[res_wr_bank] = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state       <= IDLE;
      in_full     <= '0;
      res_full    <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      res_wr_bank <= 1'b0;
      out_bank    <= 1'b0;
      first_run   <= 1'b0;
      block_index <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      in_full     <= in_full_nx;
      res_full    <= res_full_nx;
      wr_bank     <= wr_bank ^ commit_ok;
      rd_bank     <= rd_bank ^ retire;
      res_wr_bank <= res_wr_bank ^ retire;
      out_bank    <= out_bank ^ ack_ok;
      first_run   <= state == START;
      frame_done  <= retire && last;
      overflow    <= overflow | (in_commit && !in_ready);
      if (retire) block_index <= last ? '0 : block_index + CNT_W'(1);
    end
  end
endmodule
